// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage, valid/ready stream.
// Optional flags (overflow/zero/neg) are enabled by defining CLA_PIPE_FLAGS_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             sub_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int NSEG = WIDTH / SEG_W;

  // Two-level lookahead over one segment; returns {carry_out, sum}.
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] a,
                                             input logic [SEG_W-1:0] b,
                                             input logic             cin);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             t;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 1; i <= SEG_W; i++) begin
      t = cin;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  // Operands shift down one segment per stage; the result fills in from the top.
  logic [WIDTH-1:0] a_r    [NSEG];
  logic [WIDTH-1:0] b_r    [NSEG];
  logic [WIDTH-1:0] res_r  [NSEG];
  logic [NSEG-1:0]  c_r;
  logic [NSEG-1:0]  v_r;

  logic [WIDTH-1:0] pa_s   [NSEG];
  logic [WIDTH-1:0] pb_s   [NSEG];
  logic [WIDTH-1:0] pres_s [NSEG];
  logic [WIDTH-1:0] na_s   [NSEG];
  logic [WIDTH-1:0] nb_s   [NSEG];
  logic [WIDTH-1:0] nres_s [NSEG];
  logic [SEG_W:0]   seg_s  [NSEG];
  logic [NSEG-1:0]  pc_s;
  logic [NSEG-1:0]  nc_s;
  logic [NSEG-1:0]  pv_s;
  logic [NSEG-1:0]  en_s;

  // Stage inputs: stage 0 takes the beat with B inverted for subtraction.
  always_comb begin
    pa_s[0]   = src1;
    pb_s[0]   = src2 ^ {WIDTH{sub_flag}};
    pres_s[0] = '0;
    pc_s      = '0;
    pc_s[0]   = sub_flag;
    for (int k = 1; k < NSEG; k++) begin
      pa_s[k]   = a_r[k-1];
      pb_s[k]   = b_r[k-1];
      pres_s[k] = res_r[k-1];
      pc_s[k]   = c_r[k-1];
    end
    pv_s = NSEG'({v_r, in_valid});
  end

  // One CLA segment per stage.
  always_comb begin
    nc_s = '0;
    for (int k = 0; k < NSEG; k++) begin
      seg_s[k]  = cla_seg(pa_s[k][SEG_W-1:0], pb_s[k][SEG_W-1:0], pc_s[k]);
      na_s[k]   = pa_s[k] >> SEG_W;
      nb_s[k]   = pb_s[k] >> SEG_W;
      nc_s[k]   = seg_s[k][SEG_W];
      nres_s[k] = (pres_s[k] >> SEG_W) | (WIDTH'(seg_s[k][SEG_W-1:0]) << (WIDTH - SEG_W));
    end
  end

  // Advance enables ripple back from the output so bubbles collapse.
  always_comb begin
    en_s = '0;
    en_s[NSEG-1] = !v_r[NSEG-1] | out_ready;
    for (int k = NSEG - 2; k >= 0; k--) begin
      en_s[k] = !v_r[k] | en_s[k+1];
    end
  end

  // Stage registers; payload loads only with a valid beat, stalled stages hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      c_r <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        res_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (en_s[k]) v_r[k] <= pv_s[k];
        if (en_s[k] && pv_s[k]) begin
          a_r[k]   <= na_s[k];
          b_r[k]   <= nb_s[k];
          res_r[k] <= nres_s[k];
          c_r[k]   <= nc_s[k];
        end
      end
    end
  end

  assign in_ready  = en_s[0];
  assign out_valid = v_r[NSEG-1];
  assign sum       = res_r[NSEG-1];
  assign carry_out = c_r[NSEG-1];

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_s;
  logic zero_s;
  logic neg_s;
  logic ovf_r;
  logic zero_r;
  logic neg_r;

  // Flags of the final segment, using the top operand bits still held in this stage.
  always_comb begin
    ovf_s  = (pa_s[NSEG-1][SEG_W-1] == pb_s[NSEG-1][SEG_W-1]) &
             (seg_s[NSEG-1][SEG_W-1] != pa_s[NSEG-1][SEG_W-1]);
    zero_s = (nres_s[NSEG-1] == '0);
    neg_s  = seg_s[NSEG-1][SEG_W-1];
  end

  // Flags registered alongside the last-stage sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
    end else if (en_s[NSEG-1] && pv_s[NSEG-1]) begin
      ovf_r  <= ovf_s;
      zero_r <= zero_s;
      neg_r  <= neg_s;
    end
  end

  assign overflow = ovf_r;
  assign zero     = zero_r;
  assign neg      = neg_r;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign neg      = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: 32/8 main instance plus 16/16 and 48/4 instances
// scoreboarded against an arithmetic reference model.
module tb_cla_pipe_adder;
`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub_flag, out_valid, out_ready;
  logic        carry_out, overflow, zero, neg;
  logic [31:0] src1, src2, sum;
  logic        in_ready1, o1_valid, c1, ov1, z1, n1;
  logic [15:0] s1;
  logic        in_ready48, o48_valid, c48, ov48, z48, n48;
  logic [47:0] s48, a48, b48;

  assign a48 = {src2[15:0], src1};
  assign b48 = {src1[31:16], src2};

  cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .sub_flag(sub_flag), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .neg(neg));

  cla_pipe_adder #(.WIDTH(16), .SEG_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .src1(src1[15:0]), .src2(src2[15:0]), .sub_flag(sub_flag), .out_valid(o1_valid),
    .out_ready(1'b1), .sum(s1), .carry_out(c1),
    .overflow(ov1), .zero(z1), .neg(n1));

  cla_pipe_adder #(.WIDTH(48), .SEG_W(4)) dut48 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready48),
    .src1(a48), .src2(b48), .sub_flag(sub_flag), .out_valid(o48_valid),
    .out_ready(out_ready), .sum(s48), .carry_out(c48),
    .overflow(ov48), .zero(z48), .neg(n48));

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } res_t;

  res_t q32[$];
  res_t q1[$];
  res_t q48[$];
  int   checks = 0;
  int   failures = 0;
  int   ov_run = 0;
  int   ov_max = 0;
  int   ov_total = 0;
  logic prev_acc1 = 1'b0;

  // Reference: plain w-bit arithmetic and two's-complement sign rules.
  function automatic res_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic sub, input int w);
    logic [63:0] mask, a, b;
    logic [64:0] full;
    logic        as, bs, ss;
    res_t        r;
    mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
    r.s = full[63:0] & mask;
    r.c = sub ? (a >= b) : full[w];
    as = a[w-1];
    bs = b[w-1];
    ss = r.s[w-1];
    r.o = FL & (sub ? ((as != bs) && (ss != as)) : ((as == bs) && (ss != as)));
    r.z = FL & (r.s == 64'd0);
    r.n = FL & ss;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [63:0] s, input logic c,
                         input logic o, input logic z, input logic n, input res_t e);
    checks++;
    if ({s, c, o, z, n} !== {e.s, e.c, e.o, e.z, e.n}) begin
      failures++;
      $display("FAIL %s: got sum=0x%0h c=%b o=%b z=%b n=%b expected sum=0x%0h c=%b o=%b z=%b n=%b",
               name, s, c, o, z, n, e.s, e.c, e.o, e.z, e.n);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got out_valid=1 expected no outstanding beat", name);
  endtask

  // Compare process: checks every output beat against the model queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      q1.delete();
      q48.delete();
      prev_acc1 = 1'b0;
      ov_run = 0;
    end else begin
      if (out_valid) begin
        ov_total++;
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
        if (q32.size() == 0) unexpected("main_unexpected");
        else begin
          chk_res("main_result", {32'd0, sum}, carry_out, overflow, zero, neg, q32[0]);
          if (out_ready) void'(q32.pop_front());
        end
      end else begin
        ov_run = 0;
      end
      if (in_valid && in_ready)
        q32.push_back(model({32'd0, src1}, {32'd0, src2}, sub_flag, 32));

      chk("d1_latency", 64'(o1_valid), 64'(prev_acc1));
      if (o1_valid) begin
        if (q1.size() == 0) unexpected("d1_unexpected");
        else begin
          chk_res("d1_result", {48'd0, s1}, c1, ov1, z1, n1, q1[0]);
          void'(q1.pop_front());
        end
      end
      prev_acc1 = in_valid && in_ready1;
      if (in_valid && in_ready1)
        q1.push_back(model({48'd0, src1[15:0]}, {48'd0, src2[15:0]}, sub_flag, 16));

      if (o48_valid) begin
        if (q48.size() == 0) unexpected("d48_unexpected");
        else begin
          chk_res("d48_result", {16'd0, s48}, c48, ov48, z48, n48, q48[0]);
          if (out_ready) void'(q48.pop_front());
        end
      end
      if (in_valid && in_ready48)
        q48.push_back(model({16'd0, a48}, {16'd0, b48}, sub_flag, 48));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit got;
    tick();
    src1 = a;
    src2 = b;
    sub_flag = s;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] es, input logic ec,
                            input logic eo, input logic ez, input logic en, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got out_valid=0 for 60 cycles expected 1", name);
    end else begin
      chk({name, "_sum"}, 64'(sum), 64'(es));
      chk({name, "_carry"}, 64'(carry_out), 64'(ec));
      chk({name, "_ovf"}, 64'(overflow), 64'(eo));
      chk({name, "_zero"}, 64'(zero), 64'(ez));
      chk({name, "_neg"}, 64'(neg), 64'(en));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int st;
    int n;
    in_valid = 1'b0;
    src1 = 32'd0;
    src2 = 32'd0;
    sub_flag = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry_out), 64'd0);
    chk("rst_flags", 64'({overflow, zero, neg}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    expect_out("add_basic", 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    chk("latency_nseg", 64'(lat), 64'd4);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("ripple", 32'h0000_0000, 1'b1, 1'b0, FL, 1'b0, lat);
    send(32'h0000_0005, 32'h0000_0007, 1'b1);
    expect_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, FL, lat);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("ovf_add", 32'h8000_0000, 1'b0, FL, 1'b0, FL, lat);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    expect_out("ovf_sub", 32'h7FFF_FFFF, 1'b1, FL, 1'b0, 1'b0, lat);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    expect_out("sub_equal", 32'h0000_0000, 1'b1, 1'b0, FL, 1'b0, lat);

    // Streaming: 10 back-to-back beats with the consumer always ready.
    tick();
    ov_max = 0;
    st = ov_total;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src1 = (i * 32'h0101_0101) + 32'h0000_00FF;
      src2 = 32'hF0F0_F0F0 ^ i;
      sub_flag = i[0];
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stream_count", 64'(ov_total - st), 64'd10);
    chk("stream_consecutive", 64'(ov_max), 64'd10);

    // Backpressure: fill with the consumer stalled, then drain while still issuing.
    out_ready = 1'b0;
    in_valid = 1'b1;
    src1 = 32'hA5A5_0000;
    src2 = 32'h0F0F_1234;
    sub_flag = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      n++;
      tick();
      src1 = src1 + 32'h0001_1111;
      src2 = src2 ^ 32'h8000_0001;
      sub_flag = ~sub_flag;
    end
    in_valid = 1'b0;
    chk("bp_beats_held", 64'(n), 64'd4);
    chk("bp_out_valid_held", 64'(out_valid), 64'd1);
    repeat (3) tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src1 = 32'hFFFF_0000 + i;
      src2 = 32'h0001_0000;
      sub_flag = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (15) tick();
    chk("bp_drained", 64'(q32.size()), 64'd0);

    // Asynchronous reset with three beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src1 = 32'h0000_1000 * (i + 1);
      src2 = 32'h0000_0333;
      sub_flag = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_sum", 64'(sum), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    st = ov_total;
    repeat (10) tick();
    chk("rst_no_stale", 64'(ov_total - st), 64'd0);
    send(32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
    expect_out("post_rst", 32'hDEAD_D000, 1'b0, 1'b0, 1'b0, FL, lat);

    // Random traffic with random backpressure across all three widths.
    for (int i = 0; i < 1400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      src1 = $urandom();
      src2 = $urandom();
      sub_flag = $urandom_range(0, 1) != 0;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    chk("rand_drain_main", 64'(q32.size()), 64'd0);
    chk("rand_drain_d1", 64'(q1.size()), 64'd0);
    chk("rand_drain_d48", 64'(q48.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
